// File: rtl/countdown_timer.sv
// Loadable down-counting timer on the divided clock: counts a loaded value to
// zero, pulses done on expiry, supports pause/resume and optional auto-reload.
module countdown_timer #(
  parameter int WIDTH       = 4,
  parameter bit AUTO_RELOAD = 1'b0
) (
  input  logic             clk_out,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] out,
  output logic             running,
  output logic             done,
  output logic             zero
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;
  logic             running_q;

  // A pending pause suppresses start in every state, not only while running.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && !pause) begin
            if (count_q != '0) state_d = RUN;
            else               done_d  = 1'b1;
          end
        end
        RUN: begin
          if (pause) begin
            state_d = PAUSED;
          end else if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            done_d = 1'b1;
            if (AUTO_RELOAD) begin
              count_d = reload_q;
            end else begin
              count_d = '0;
              state_d = EXPIRED;
            end
          end else begin
            state_d = EXPIRED;
          end
        end
        PAUSED: begin
          if (start && !pause) state_d = RUN;
        end
        EXPIRED: begin
          if (start && !pause) begin
            if (reload_q != '0) begin
              count_d = reload_q;
              state_d = RUN;
            end else begin
              done_d = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_out) begin
    if (!rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      done_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      done_q    <= done_d;
      running_q <= (state_d == RUN);
    end
  end

  assign out     = count_q;
  assign running = running_q;
  assign done    = done_q;
  assign zero    = (count_q == '0);

endmodule
